// File: rtl/uart_pkg.sv
// Shared definitions for the 12-bit telemetry UART receive path:
// packet tag values and the byte receiver state encoding.
package uart_pkg;

    // Tag carried in bits [7:6] of each packet byte.
    localparam logic [1:0] TAG_HI = 2'b10;
    localparam logic [1:0] TAG_LO = 2'b01;

    // Byte receiver states.
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_DATA  = 3'd2,
        ST_STOP  = 3'd3,
        ST_BREAK = 3'd4
    } rx_state_t;

endpackage

// File: rtl/uart_rx_core.sv
// 8N1 byte receiver: 2-flop synchroniser, bit counter and byte FSM.
// rx_byte_valid and frame_err are combinational pulses raised during the
// stop-bit sample cycle; the top registers them one cycle later.
// Handshake: rx_byte_valid is a single-cycle strobe with no back-pressure;
// rx_byte is stable whenever rx_byte_valid is high.
module uart_rx_core
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 278
) (
    input  logic       clk_i,
    input  logic       rst_n,
    input  logic       rxd,
    output logic [7:0] rx_byte,
    output logic       rx_byte_valid,
    output logic       frame_err,
    output logic       busy
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] CNT_MID = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] CNT_END = CW'(CLKS_PER_BIT - 1);

    logic            sync1_q, sync2_q;
    rx_state_t       state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [2:0]      bit_q, bit_d;
    logic [7:0]      shift_q, shift_d;

    // Synchronise the asynchronous line; idle level is high.
    always_ff @(posedge clk_i) begin
        if (!rst_n) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
        end else begin
            sync1_q <= rxd;
            sync2_q <= sync1_q;
        end
    end

    // State register, bit counter, bit index and shift register.
    always_ff @(posedge clk_i) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            bit_q   <= 3'd0;
            shift_q <= 8'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
        end
    end

    // Next-state logic: half-bit start check, then mid-bit sampling.
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q + 1'b1;
        bit_d         = bit_q;
        shift_d       = shift_q;
        rx_byte_valid = 1'b0;
        frame_err     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (!sync2_q) begin
                    state_d = ST_START;
                    bit_d   = 3'd0;
                end
            end
            ST_START: begin
                if (cnt_q == CNT_MID) begin
                    cnt_d   = '0;
                    state_d = sync2_q ? ST_IDLE : ST_DATA;
                end
            end
            ST_DATA: begin
                if (cnt_q == CNT_END) begin
                    cnt_d   = '0;
                    shift_d = {sync2_q, shift_q[7:1]};
                    bit_d   = bit_q + 3'd1;
                    if (bit_q == 3'd7) begin
                        state_d = ST_STOP;
                    end
                end
            end
            ST_STOP: begin
                if (cnt_q == CNT_END) begin
                    cnt_d = '0;
                    if (sync2_q) begin
                        rx_byte_valid = 1'b1;
                        state_d       = ST_IDLE;
                    end else begin
                        frame_err = 1'b1;
                        state_d   = ST_BREAK;
                    end
                end
            end
            ST_BREAK: begin
                cnt_d = '0;
                if (sync2_q) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                cnt_d   = '0;
                state_d = ST_IDLE;
            end
        endcase
    end

    assign rx_byte = shift_q;
    assign busy    = (state_q != ST_IDLE);

endmodule

// File: rtl/uart_rx_top.sv
// Telemetry receive top: reassembles tagged high/low 6-bit packets from the
// byte receiver into 12-bit words. All strobes are registered, so they appear
// one cycle after the stop-bit sample and are exactly one cycle wide.
module uart_rx_top
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 278
) (
    input  logic        clk_i,
    input  logic        rst_n,
    input  logic        rxd,
    output logic [11:0] data_o,
    output logic        data_valid_o,
    output logic        frame_err_o,
    output logic        sync_err_o,
    output logic        busy_o
);

    logic [7:0]  rx_byte;
    logic        rx_byte_valid, frame_err, busy;

    logic        hi_pend_q, hi_pend_d;
    logic [5:0]  hi_q, hi_d;
    logic [11:0] data_q, data_d;
    logic        valid_q, valid_d;
    logic        ferr_q, ferr_d;
    logic        serr_q, serr_d;

    uart_rx_core #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_core (
        .clk_i         (clk_i),
        .rst_n         (rst_n),
        .rxd           (rxd),
        .rx_byte       (rx_byte),
        .rx_byte_valid (rx_byte_valid),
        .frame_err     (frame_err),
        .busy          (busy)
    );

    // Reassembler decisions; a framing error also drops a pending high half.
    always_comb begin
        hi_pend_d = hi_pend_q;
        hi_d      = hi_q;
        data_d    = data_q;
        valid_d   = 1'b0;
        ferr_d    = 1'b0;
        serr_d    = 1'b0;
        if (frame_err) begin
            ferr_d    = 1'b1;
            hi_pend_d = 1'b0;
        end else if (rx_byte_valid) begin
            case (rx_byte[7:6])
                TAG_HI: begin
                    serr_d    = hi_pend_q;
                    hi_d      = rx_byte[5:0];
                    hi_pend_d = 1'b1;
                end
                TAG_LO: begin
                    if (hi_pend_q) begin
                        data_d    = {hi_q, rx_byte[5:0]};
                        valid_d   = 1'b1;
                        hi_pend_d = 1'b0;
                    end else begin
                        serr_d = 1'b1;
                    end
                end
                default: begin
                    serr_d    = 1'b1;
                    hi_pend_d = 1'b0;
                end
            endcase
        end
    end

    // Reassembler state and registered outputs.
    always_ff @(posedge clk_i) begin
        if (!rst_n) begin
            hi_pend_q <= 1'b0;
            hi_q      <= 6'd0;
            data_q    <= 12'd0;
            valid_q   <= 1'b0;
            ferr_q    <= 1'b0;
            serr_q    <= 1'b0;
        end else begin
            hi_pend_q <= hi_pend_d;
            hi_q      <= hi_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            ferr_q    <= ferr_d;
            serr_q    <= serr_d;
        end
    end

    assign data_o       = data_q;
    assign data_valid_o = valid_q;
    assign frame_err_o  = ferr_q;
    assign sync_err_o   = serr_q;
    assign busy_o       = busy;

endmodule
